// File: rtl/tape_pkg.sv
// Shared types and helpers for the cassette capture path.
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    DATA,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    BIT0,
    BIT1,
    LOST
  } bit_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 2;

  // Map a measured period (in ce_tick units) onto a decoded symbol.
  function automatic bit_t classify_period(input int unsigned period,
                                           input int unsigned thresh,
                                           input int unsigned timeout);
    if (period < thresh)
      return BIT1;
    else if (period < timeout)
      return BIT0;
    else
      return LOST;
  endfunction

endpackage

// File: rtl/tape_period_meter.sv
// Synchronises cass_in, measures rising-edge to rising-edge periods in
// ce_tick units and emits one decoded symbol per completed period.
module tape_period_meter
  import tape_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int THRESH  = 48,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_tick,
  input  logic cass_in,
  input  logic disarm,
  output logic bit_valid,
  output bit_t bit_val
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE_TIMEOUT = CNT_W'(TIMEOUT - 1);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             rise;
  logic             timeout_hit;

  assign rise        = sync_q[1] & ~sync_q[2];
  // The tick that carries the counter onto TIMEOUT is the carrier-lost event.
  assign timeout_hit = armed & ce_tick & ~rise & (cnt == CNT_PRE_TIMEOUT);

  // Synchroniser, saturating period counter, arm/disarm and symbol output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      bit_valid <= 1'b0;
      bit_val   <= BIT0;
    end else begin
      sync_q    <= {sync_q[1:0], cass_in};
      bit_valid <= 1'b0;

      // An edge always wins over a coincident tick.
      if (rise)
        cnt <= '0;
      else if (ce_tick && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;

      // An edge while disarmed (or while being disarmed) only arms the meter.
      if (rise) begin
        if (armed && !disarm) begin
          bit_valid <= 1'b1;
          bit_val   <= classify_period(32'(cnt), THRESH, TIMEOUT);
        end
        armed <= 1'b1;
      end else if (disarm) begin
        armed <= 1'b0;
      end else if (timeout_hit) begin
        armed     <= 1'b0;
        bit_valid <= 1'b1;
        bit_val   <= LOST;
      end
    end
  end

endmodule

// File: rtl/tape_recorder.sv
// Cassette capture: frames decoded symbols into bytes and writes them
// sequentially into the tape RAM.
module tape_recorder
  import tape_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int THRESH  = 48,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_tick,
  input  logic        enable,
  input  logic        cass_in,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        we,
  output logic [15:0] length,
  output logic        active,
  output logic        frame_err,
  output logic        overflow
);

  state_t      state;
  logic        enable_d;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic        stopcnt;
  logic [15:0] len_q;
  logic        bit_valid;
  bit_t        bit_val;

  // The write address always equals the byte count: a write lands at
  // length, and length advances the clock after the strobe.
  assign length = len_q;
  assign addr   = len_q;

  // Meter stays disarmed while idle so the first edge after arming never
  // produces a bit. Returning to HUNT after a good frame keeps it armed so
  // back-to-back frames decode without a lost start bit.
  tape_period_meter #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH),
    .TIMEOUT(TIMEOUT)
  ) u_meter (
    .clk      (clk),
    .reset    (reset),
    .ce_tick  (ce_tick),
    .cass_in  (cass_in),
    .disarm   (state == IDLE),
    .bit_valid(bit_valid),
    .bit_val  (bit_val)
  );

  // Frame FSM, shift register and RAM write sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      enable_d  <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      stopcnt   <= 1'b0;
      len_q     <= '0;
      data      <= '0;
      we        <= 1'b0;
      active    <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      enable_d <= enable;
      we       <= 1'b0;

      if (we)
        len_q <= len_q + 16'd1;

      if (!enable) begin
        state  <= IDLE;
        active <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!enable_d) begin
              len_q     <= '0;
              frame_err <= 1'b0;
              overflow  <= 1'b0;
              state     <= HUNT;
            end
          end
          HUNT: begin
            if (bit_valid && (bit_val == BIT0)) begin
              bitcnt <= '0;
              active <= 1'b1;
              state  <= DATA;
            end
          end
          DATA: begin
            if (bit_valid) begin
              if (bit_val == LOST) begin
                active <= 1'b0;
                state  <= HUNT;
              end else begin
                shreg  <= {shreg[6:0], bit_val == BIT1};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'(DATA_BITS - 1)) begin
                  stopcnt <= 1'b0;
                  state   <= STOP;
                end
              end
            end
          end
          STOP: begin
            if (bit_valid) begin
              if (bit_val == LOST) begin
                active <= 1'b0;
                state  <= HUNT;
              end else begin
                if (bit_val == BIT0)
                  frame_err <= 1'b1;
                if (stopcnt == 1'(STOP_BITS - 1)) begin
                  active <= 1'b0;
                  state  <= HUNT;
                  if (len_q == 16'hFFFF) begin
                    overflow <= 1'b1;
                  end else begin
                    we   <= 1'b1;
                    data <= shreg;
                  end
                end else begin
                  stopcnt <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
